// File: rtl/regfile_pkg.sv
// Shared helpers for the multi-port register file: address-width and lane-mask functions.
package regfile_pkg;

    localparam int unsigned MAX_WIDTH = 256;
    localparam int unsigned MAX_LANES = 256;
    localparam int unsigned MW_AW     = $clog2(MAX_WIDTH);
    localparam int unsigned ML_AW     = $clog2(MAX_LANES);

    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Expands one strobe bit per lane into a bit-level mask.
    function automatic logic [MAX_WIDTH-1:0] lane_mask(input logic [MAX_LANES-1:0] strb,
                                                       input int unsigned lane_w);
        logic [MAX_WIDTH-1:0] m;
        m = '0;
        for (int unsigned j = 0; j < MAX_WIDTH; j++) begin
            m[MW_AW'(j)] = strb[ML_AW'(j / lane_w)];
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_mp_bypass_async_rstn_reg.sv
// Enabled register with asynchronous active-low reset; one storage lane of the register file.
module register_en_async_rstn #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)   q <= RESET_VAL;
        else if (en) q <= d;
    end

endmodule

// File: rtl/regfile_mp_bypass_async_rstn_wsel.sv
// Per-register write select: resolves lane-wise port priority, yields next value, lane updates and conflict.
module regfile_wsel
    import regfile_pkg::*;
#(
    parameter  int unsigned WIDTH     = 32,
    parameter  int unsigned LANE_W    = 8,
    parameter  int unsigned N_WPORTS  = 1,
    parameter  int unsigned AW        = 5,
    parameter  int unsigned REG_IDX   = 0,
    parameter  int unsigned ZERO_REG0 = 0,
    localparam int unsigned NL        = WIDTH / LANE_W
) (
    input  logic [N_WPORTS-1:0]            wen,
    input  logic [N_WPORTS-1:0][AW-1:0]    waddr,
    input  logic [N_WPORTS-1:0][NL-1:0]    wstrb,
    input  logic [N_WPORTS-1:0][WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0]               cur,
    output logic [WIDTH-1:0]               nxt,
    output logic [NL-1:0]                  lane_upd,
    output logic                           conflict
);

    localparam bit BLOCKED = (ZERO_REG0 != 0) && (REG_IDX == 0);

    logic [N_WPORTS-1:0] hit;
    logic [WIDTH-1:0]    wval;
    logic [WIDTH-1:0]    mask;

    always_comb begin
        hit      = '0;
        lane_upd = '0;
        wval     = '0;
        conflict = 1'b0;
        for (int unsigned p = 0; p < N_WPORTS; p++) begin
            hit[p] = wen[p] && (waddr[p] == AW'(REG_IDX)) && !BLOCKED;
        end
        // Ascending port scan: a later hit overwrites the lane, so the highest index wins.
        for (int unsigned k = 0; k < NL; k++) begin
            for (int unsigned p = 0; p < N_WPORTS; p++) begin
                if (hit[p] && wstrb[p][k]) begin
                    if (lane_upd[k]) conflict = 1'b1;
                    lane_upd[k] = 1'b1;
                    wval[k*LANE_W +: LANE_W] = wdata[p][k*LANE_W +: LANE_W];
                end
            end
        end
        mask = WIDTH'(lane_mask(MAX_LANES'(lane_upd), LANE_W));
        nxt  = (cur & ~mask) | wval;
    end

endmodule

// File: rtl/regfile_mp_bypass_async_rstn.sv
// Multi-port register file with lane strobes, port priority, optional zero reg and registered/bypassed reads.
module regfile_mp_bypass_async_rstn
    import regfile_pkg::*;
#(
    parameter  int unsigned      WIDTH     = 32,
    parameter  int unsigned      N_REG     = 32,
    parameter  int unsigned      N_RPORTS  = 2,
    parameter  int unsigned      N_WPORTS  = 1,
    parameter  int unsigned      LANE_W    = 8,
    parameter  int unsigned      READ_LAT  = 0,
    parameter  int unsigned      BYPASS    = 1,
    parameter  int unsigned      ZERO_REG0 = 0,
    parameter  logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned      AW        = clog2_min1(N_REG),
    localparam int unsigned      NL        = WIDTH / LANE_W
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [N_RPORTS-1:0]            ren,
    input  logic [N_RPORTS-1:0][AW-1:0]    raddr,
    output logic [N_RPORTS-1:0][WIDTH-1:0] rdata,
    input  logic [N_WPORTS-1:0]            wen,
    input  logic [N_WPORTS-1:0][AW-1:0]    waddr,
    input  logic [N_WPORTS-1:0][NL-1:0]    wstrb,
    input  logic [N_WPORTS-1:0][WIDTH-1:0] wdata,
    output logic                           wcollide
);

    logic [N_REG-1:0][NL-1:0][LANE_W-1:0] store;
    logic [N_REG-1:0][WIDTH-1:0]          nxt;
    logic [N_REG-1:0][NL-1:0]             upd;
    logic [N_REG-1:0]                     conf;
    logic [N_RPORTS-1:0][WIDTH-1:0]       rd_val;

    for (genvar i = 0; i < N_REG; i++) begin : g_reg
        regfile_wsel #(
            .WIDTH     (WIDTH),
            .LANE_W    (LANE_W),
            .N_WPORTS  (N_WPORTS),
            .AW        (AW),
            .REG_IDX   (i),
            .ZERO_REG0 (ZERO_REG0)
        ) u_wsel (
            .wen      (wen),
            .waddr    (waddr),
            .wstrb    (wstrb),
            .wdata    (wdata),
            .cur      (store[i]),
            .nxt      (nxt[i]),
            .lane_upd (upd[i]),
            .conflict (conf[i])
        );

        for (genvar k = 0; k < NL; k++) begin : g_lane
            register_en_async_rstn #(
                .WIDTH     (LANE_W),
                .RESET_VAL (RESET_VAL[k*LANE_W +: LANE_W])
            ) u_lane (
                .clk  (clk),
                .rstn (rstn),
                .en   (upd[i][k]),
                .d    (nxt[i][k*LANE_W +: LANE_W]),
                .q    (store[i][k])
            );
        end
    end

    // The select's next value doubles as the forwarded (write-first) read value.
    always_comb begin
        rd_val = '0;
        for (int unsigned r = 0; r < N_RPORTS; r++) begin
            for (int unsigned i = 0; i < N_REG; i++) begin
                if ((raddr[r] == AW'(i)) && !((ZERO_REG0 != 0) && (i == 0))) begin
                    rd_val[r] = (BYPASS != 0) ? nxt[i] : store[i];
                end
            end
        end
    end

    if (READ_LAT != 0) begin : g_rd_reg
        logic [N_RPORTS-1:0][WIDTH-1:0] rdata_q;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                rdata_q <= '0;
            end else begin
                for (int unsigned r = 0; r < N_RPORTS; r++) begin
                    if (ren[r]) rdata_q[r] <= rd_val[r];
                end
            end
        end

        assign rdata = rdata_q;
    end else begin : g_rd_comb
        logic ren_unused;
        assign ren_unused = ^ren;
        assign rdata      = rd_val;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) wcollide <= 1'b0;
        else       wcollide <= |conf;
    end

endmodule

// File: tb/tb_regfile_mp_bypass_async_rstn.sv
// Bench: three read-path variants driven in parallel, checked every cycle against a behavioural model.
module tb_regfile_mp_bypass_async_rstn;

    localparam logic [31:0] RV = 32'hA5A5_A5A5;
    localparam int NREG = 20;

    logic             clk = 1'b0;
    logic             rstn;
    logic [1:0]       ren;
    logic [1:0][4:0]  raddr;
    logic [1:0]       wen;
    logic [1:0][4:0]  waddr;
    logic [1:0][3:0]  wstrb;
    logic [1:0][31:0] wdata;

    logic [1:0][31:0] rdata_a, rdata_b, rdata_c;
    logic             wcollide_a, wcollide_b, wcollide_c;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    regfile_mp_bypass_async_rstn #(
        .WIDTH(32), .N_REG(NREG), .N_RPORTS(2), .N_WPORTS(2), .LANE_W(8),
        .READ_LAT(1), .BYPASS(1), .ZERO_REG0(1), .RESET_VAL(RV)
    ) u_a (
        .clk(clk), .rstn(rstn), .ren(ren), .raddr(raddr), .rdata(rdata_a),
        .wen(wen), .waddr(waddr), .wstrb(wstrb), .wdata(wdata), .wcollide(wcollide_a)
    );

    regfile_mp_bypass_async_rstn #(
        .WIDTH(32), .N_REG(NREG), .N_RPORTS(2), .N_WPORTS(2), .LANE_W(8),
        .READ_LAT(1), .BYPASS(0), .ZERO_REG0(1), .RESET_VAL(RV)
    ) u_b (
        .clk(clk), .rstn(rstn), .ren(ren), .raddr(raddr), .rdata(rdata_b),
        .wen(wen), .waddr(waddr), .wstrb(wstrb), .wdata(wdata), .wcollide(wcollide_b)
    );

    regfile_mp_bypass_async_rstn #(
        .WIDTH(32), .N_REG(NREG), .N_RPORTS(2), .N_WPORTS(2), .LANE_W(8),
        .READ_LAT(0), .BYPASS(1), .ZERO_REG0(1), .RESET_VAL(RV)
    ) u_c (
        .clk(clk), .rstn(rstn), .ren(ren), .raddr(raddr), .rdata(rdata_c),
        .wen(wen), .waddr(waddr), .wstrb(wstrb), .wdata(wdata), .wcollide(wcollide_c)
    );

    // ---------------- behavioural model ----------------
    logic [31:0]      mem [NREG];
    logic [1:0][31:0] ma, mb;
    logic             mcol;

    // Contents of register a once the current write requests are applied in port order.
    function automatic logic [31:0] post_val(input int a);
        logic [31:0] v;
        v = mem[a];
        if (a == 0) return v;
        for (int p = 0; p < 2; p++) begin
            if (wen[p] && int'(waddr[p]) == a) begin
                for (int k = 0; k < 4; k++) begin
                    if (wstrb[p][k]) v[8*k +: 8] = wdata[p][8*k +: 8];
                end
            end
        end
        return v;
    endfunction

    function automatic logic [31:0] model_rd(input int a, input bit fwd);
        if (a == 0 || a >= NREG) return 32'h0;
        return fwd ? post_val(a) : mem[a];
    endfunction

    function automatic bit model_col();
        int a;
        a = int'(waddr[0]);
        return wen[0] && wen[1] && (waddr[0] == waddr[1]) && (a > 0) && (a < NREG)
               && ((wstrb[0] & wstrb[1]) != 4'h0);
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) mem[i] <= RV;
            ma   <= '0;
            mb   <= '0;
            mcol <= 1'b0;
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (ren[r]) begin
                    ma[r] <= model_rd(int'(raddr[r]), 1'b1);
                    mb[r] <= model_rd(int'(raddr[r]), 1'b0);
                end
            end
            mcol <= model_col();
            for (int i = 0; i < NREG; i++) mem[i] <= post_val(i);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && chk_en) begin
            for (int r = 0; r < 2; r++) begin
                check($sformatf("cmp_a_rd%0d", r), rdata_a[r], ma[r]);
                check($sformatf("cmp_b_rd%0d", r), rdata_b[r], mb[r]);
                check($sformatf("cmp_c_rd%0d", r), rdata_c[r], model_rd(int'(raddr[r]), 1'b1));
            end
            check("cmp_a_col", 32'(wcollide_a), 32'(mcol));
            check("cmp_b_col", 32'(wcollide_b), 32'(mcol));
            check("cmp_c_col", 32'(wcollide_c), 32'(mcol));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen   = '0;
        waddr = '0;
        wstrb = '0;
        wdata = '0;
    endtask

    task automatic wr(input int p, input int a, input logic [3:0] s, input logic [31:0] d);
        wen[p]   = 1'b1;
        waddr[p] = 5'(a);
        wstrb[p] = s;
        wdata[p] = d;
    endtask

    task automatic sweep();
        ren = 2'b11;
        for (int a = 0; a < 22; a++) begin
            raddr[0] = 5'(a);
            raddr[1] = 5'(21 - a);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn  = 1'b1;
        ren   = '0;
        raddr = '0;
        idle();
        #1 rstn = 1'b0;
        #2;
        check("rst_a_rdata", rdata_a[0], 32'h0);
        check("rst_b_rdata", rdata_b[1], 32'h0);
        check("rst_col", 32'(wcollide_a), 32'h0);
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        chk_en = 1'b1;
        tick();

        // 1: every register reads its reset value
        ren = 2'b11;
        for (int a = 0; a < NREG; a++) begin
            raddr[0] = 5'(a);
            raddr[1] = 5'(NREG - 1 - a);
            #1;
            if (a == 3) check("t1_c_r3", rdata_c[0], RV);
            if (a == 0) check("t1_c_r0", rdata_c[0], 32'h0);
            tick();
        end

        // 2: lane strobes
        wr(0, 3, 4'hF, 32'h1122_3344);
        tick();
        idle();
        wr(0, 3, 4'b0101, 32'hFFFF_FFFF);
        tick();
        idle();
        raddr[0] = 5'd3;
        #1 check("t2_c", rdata_c[0], 32'h11FF_33FF);
        tick();
        check("t2_a", rdata_a[0], 32'h11FF_33FF);

        // 3: same-lane conflict, then disjoint merge
        raddr[0] = 5'd5;
        tick();
        wr(0, 5, 4'hF, 32'h1);
        wr(1, 5, 4'hF, 32'h2);
        #1 check("t3_c_fwd", rdata_c[0], 32'h2);
        tick();
        idle();
        check("t3_col", 32'(wcollide_a), 32'h1);
        check("t3_a", rdata_a[0], 32'h2);
        check("t3_b", rdata_b[0], RV);
        tick();
        check("t3_col_clr", 32'(wcollide_a), 32'h0);
        wr(0, 5, 4'b0011, 32'h1111_1111);
        wr(1, 5, 4'b1100, 32'h2222_2222);
        tick();
        idle();
        check("t3_merge_col", 32'(wcollide_a), 32'h0);
        #1 check("t3_merge", rdata_c[0], 32'h2222_1111);

        // 4: write-first vs read-first capture
        raddr[0] = 5'd7;
        tick();
        wr(0, 7, 4'hF, 32'hDEAD_BEEF);
        #1 check("t4_c_same", rdata_c[0], 32'hDEAD_BEEF);
        tick();
        idle();
        check("t4_a_wf", rdata_a[0], 32'hDEAD_BEEF);
        check("t4_b_rf", rdata_b[0], RV);

        // 5: zero register, out-of-range, collisions that must not count, ren hold
        raddr[1] = 5'd0;
        wr(0, 0, 4'hF, 32'h5);
        #1 check("t5_c_z0", rdata_c[1], 32'h0);
        tick();
        idle();
        check("t5_a_z0", rdata_a[1], 32'h0);
        raddr[1] = 5'd25;
        wr(1, 25, 4'hF, 32'h1234_5678);
        #1 check("t5_c_oor", rdata_c[1], 32'h0);
        tick();
        idle();
        check("t5_a_oor", rdata_a[1], 32'h0);
        wr(0, 0, 4'hF, 32'h1);
        wr(1, 0, 4'hF, 32'h2);
        tick();
        idle();
        check("t5_z0_nocol", 32'(wcollide_a), 32'h0);
        wr(0, 25, 4'hF, 32'h1);
        wr(1, 25, 4'hF, 32'h2);
        tick();
        idle();
        check("t5_oor_nocol", 32'(wcollide_a), 32'h0);
        ren = 2'b00;
        raddr[0] = 5'd3;
        tick();
        check("t5_hold_a", rdata_a[0], 32'hDEAD_BEEF);
        check("t5_hold_b", rdata_b[0], 32'hDEAD_BEEF);
        sweep();

        // mixed traffic with varied addresses, strobes and enables
        for (int i = 0; i < 40; i++) begin
            idle();
            wr(0, (i * 7) % 22, 4'((i * 3) % 16), (32'(i) * 32'h0101_0101) ^ 32'h5A3C_0F96);
            if (i % 3 != 0)
                wr(1, (i * 5 + 1) % 22, 4'((i * 11 + 5) % 16), ~(32'(i) * 32'h0102_0408));
            raddr[0] = 5'((i * 3) % 22);
            raddr[1] = 5'((i * 7) % 22);
            ren = 2'(i % 4);
            tick();
        end
        idle();
        sweep();

        // 6: reset mid-stream with reads and writes pending
        wr(0, 9, 4'hF, 32'hCAFE_0000);
        wr(1, 9, 4'h3, 32'h0000_BEEF);
        ren = 2'b11;
        raddr[0] = 5'd3;
        raddr[1] = 5'd4;
        #2 rstn = 1'b0;
        #1;
        check("t6_a_rd0", rdata_a[0], 32'h0);
        check("t6_a_rd1", rdata_a[1], 32'h0);
        check("t6_b_rd0", rdata_b[0], 32'h0);
        check("t6_col", 32'(wcollide_a), 32'h0);
        check("t6_c_rd0", rdata_c[0], RV);
        check("t6_c_rd1", rdata_c[1], RV);
        tick();
        check("t6_a_held_rst", rdata_a[0], 32'h0);
        idle();
        @(negedge clk);
        #2 rstn = 1'b1;
        tick();
        raddr[1] = 5'd9;
        #1 check("t6_c_r9", rdata_c[1], RV);
        check("t6_a_rd0_rel", rdata_a[0], RV);
        sweep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
